// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side master for the synchronous FIFO. Issues FIFO reads, absorbs the
// FIFO's one-cycle registered read latency in a small skid buffer, and presents
// the words as a valid/ready stream with no bubbles and no data loss.
//
// Ports
//   clk_i         clock shared with the FIFO and the sink
//   rst_n_i       asynchronous active-low reset
//   enable_i      1 = new FIFO reads may be issued; buffered words always drain
//   flush_i       synchronous discard of buffered and in-flight words
//   fifo_empty_i  FIFO empty flag
//   fifo_rdata_i  FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en_o  FIFO read enable (combinational, includes m_ready_i)
//   m_data_o      stream data (head of the skid buffer)
//   m_valid_o     stream valid
//   m_ready_i     stream ready from the sink
//   xfer_cnt_o    number of completed stream handshakes (wraps)
//   level_o       skid buffer occupancy
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int WIDTH      = 32,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          enable_i,
    input  logic                          flush_i,
    input  logic                          fifo_empty_i,
    input  logic [WIDTH-1:0]              fifo_rdata_i,
    output logic                          fifo_rd_en_o,
    output logic [WIDTH-1:0]              m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [CNT_W-1:0]              xfer_cnt_o,
    output logic [$clog2(SKID_DEPTH):0]   level_o
);

    localparam int LVL_W = $clog2(SKID_DEPTH) + 1;
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam logic [LVL_W:0]   DEPTH_CMP = (LVL_W + 1)'(SKID_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SKID_DEPTH - 1);

    logic [WIDTH-1:0] mem_reg [SKID_DEPTH];
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [LVL_W-1:0] level_reg, level_next;
    logic             valid_reg;
    logic             inflight_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             pop;
    logic             capture;
    logic [LVL_W:0]   committed;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign pop     = valid_reg & m_ready_i;
    // inflight_reg means fifo_rdata_i carries a real word this cycle.
    assign capture = inflight_reg & ~flush_i;

    // Slots already spoken for once this cycle's pop (if any) is taken out.
    // The m_ready_i dependency here is what allows one word per cycle.
    assign committed = {1'b0, level_reg}
                     + (LVL_W + 1)'(inflight_reg)
                     - (LVL_W + 1)'(pop);

    // rst_n_i is folded in so no read can be issued while held in reset.
    assign rd_en = rst_n_i & enable_i & ~flush_i & ~fifo_empty_i
                 & (committed < DEPTH_CMP);

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        level_next = level_reg;
        if (flush_i) begin
            head_next  = '0;
            tail_next  = '0;
            level_next = '0;
        end else begin
            if (pop)
                head_next = ptr_inc(head_reg);
            if (capture)
                tail_next = ptr_inc(tail_reg);
            level_next = level_reg + LVL_W'(capture) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            level_reg    <= '0;
            valid_reg    <= 1'b0;
            inflight_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            level_reg    <= level_next;
            // Registered copy of (level != 0) so the valid output is a flop.
            valid_reg    <= (level_next != '0);
            inflight_reg <= rd_en;
            // A pop in a flush cycle still completes, so it is counted.
            if (pop)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    mem_reg[gi] <= '0;
                else if (capture && (tail_reg == PTR_W'(gi)))
                    mem_reg[gi] <= fifo_rdata_i;
            end
        end
    endgenerate

    assign fifo_rd_en_o = rd_en;
    assign m_data_o     = mem_reg[head_reg];
    assign m_valid_o    = valid_reg;
    assign xfer_cnt_o   = cnt_reg;
    assign level_o      = level_reg;

endmodule
